// File: rtl/ov7670_dvp_source_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_dvp_source_pkg
// Description : Shared FSM encodings, pattern codes and colour-bar constants
//               for the OV7670-style DVP test-pattern source.
// Revision    : 1.0 - initial release
// ============================================================================
package ov7670_dvp_source_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_VSYNC   = 3'd1,
        ST_V_BACK  = 3'd2,
        ST_ACTIVE  = 3'd3,
        ST_V_FRONT = 3'd4
    } dvp_state_t;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_SOLID   = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_t;

    localparam logic [15:0] c_bar_white   = 16'hFFFF;
    localparam logic [15:0] c_bar_yellow  = 16'hFFE0;
    localparam logic [15:0] c_bar_cyan    = 16'h07FF;
    localparam logic [15:0] c_bar_green   = 16'h07E0;
    localparam logic [15:0] c_bar_magenta = 16'hF81F;
    localparam logic [15:0] c_bar_red     = 16'hF800;
    localparam logic [15:0] c_bar_blue    = 16'h001F;
    localparam logic [15:0] c_bar_black   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] v;
        case (idx)
            3'd0:    v = c_bar_white;
            3'd1:    v = c_bar_yellow;
            3'd2:    v = c_bar_cyan;
            3'd3:    v = c_bar_green;
            3'd4:    v = c_bar_magenta;
            3'd5:    v = c_bar_red;
            3'd6:    v = c_bar_blue;
            default: v = c_bar_black;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ov7670_pattern_pixel.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_pattern_pixel
// Description : Registered RGB565 test-pattern pixel generator driven by
//               frame-start, line-start and pixel-step strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_pattern_pixel
    import ov7670_dvp_source_pkg::*;
#(
    parameter int FRAME_WIDTH = 640
)(
    input  logic        PixelClk,
    input  logic        nRST,
    input  pattern_t    pattern,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        x_step,
    input  logic        y_bit3,
    input  logic [15:0] solid,
    output logic [15:0] pix
);

    localparam int BAR_W = FRAME_WIDTH / 8;
    localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [2:0]     r_bar,     w_bar_n;
    logic [BPW-1:0] r_bar_pos, w_bar_pos_n;
    logic [2:0]     r_chk_cnt, w_chk_cnt_n;
    logic           r_x3,      w_x3_n;
    logic           r_y3,      w_y3_n;
    logic [15:0]    r_ramp,    w_ramp_n;
    logic [15:0]    w_pix_n;

    // Next-state describes the pixel that becomes current after this edge.
    always_comb begin
        w_bar_n     = r_bar;
        w_bar_pos_n = r_bar_pos;
        w_chk_cnt_n = r_chk_cnt;
        w_x3_n      = r_x3;
        w_y3_n      = r_y3;
        w_ramp_n    = r_ramp;
        if (line_start) begin
            w_bar_n     = 3'd0;
            w_bar_pos_n = '0;
            w_chk_cnt_n = 3'd0;
            w_x3_n      = 1'b0;
            w_y3_n      = y_bit3;
        end else if (x_step) begin
            if (r_bar_pos == BPW'(BAR_W - 1)) begin
                w_bar_pos_n = '0;
                w_bar_n     = r_bar + 3'd1;
            end else begin
                w_bar_pos_n = r_bar_pos + BPW'(1);
            end
            w_chk_cnt_n = r_chk_cnt + 3'd1;
            if (r_chk_cnt == 3'd7) begin
                w_x3_n = ~r_x3;
            end
        end
        if (frame_start) begin
            w_ramp_n = 16'd0;
        end else if (x_step) begin
            w_ramp_n = r_ramp + 16'd1;
        end

        case (pattern)
            PAT_BARS:  w_pix_n = bar_colour(w_bar_n);
            PAT_RAMP:  w_pix_n = w_ramp_n;
            PAT_SOLID: w_pix_n = solid;
            default:   w_pix_n = (w_x3_n ^ w_y3_n) ? 16'hFFFF : 16'h0000;
        endcase
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_bar     <= 3'd0;
            r_bar_pos <= '0;
            r_chk_cnt <= 3'd0;
            r_x3      <= 1'b0;
            r_y3      <= 1'b0;
            r_ramp    <= 16'd0;
            pix       <= 16'd0;
        end else begin
            r_bar     <= w_bar_n;
            r_bar_pos <= w_bar_pos_n;
            r_chk_cnt <= w_chk_cnt_n;
            r_x3      <= w_x3_n;
            r_y3      <= w_y3_n;
            r_ramp    <= w_ramp_n;
            pix       <= w_pix_n;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ov7670_dvp_source.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_dvp_source
// Description : Cycle-accurate OV7670-style DVP transmitter emitting RGB565
//               test-pattern frames on cam_vsync / href / p_data.
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_dvp_source
    import ov7670_dvp_source_pkg::*;
#(
    parameter int FRAME_WIDTH   = 640,
    parameter int FRAME_HEIGHT  = 480,
    parameter int H_BLANK       = 144,
    parameter int VSYNC_LINES   = 3,
    parameter int V_BACK_LINES  = 17,
    parameter int V_FRONT_LINES = 10
)(
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic        cam_vsync,
    output logic        href,
    output logic [7:0]  p_data,
    output logic        frame_done
);

    localparam int LP   = 2 * FRAME_WIDTH + H_BLANK;
    localparam int CW   = $clog2(LP);
    localparam int YW   = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int LM1  = (VSYNC_LINES > V_BACK_LINES) ? VSYNC_LINES : V_BACK_LINES;
    localparam int LMAX = (LM1 > V_FRONT_LINES) ? LM1 : V_FRONT_LINES;
    localparam int LW   = $clog2(LMAX + 1);

    dvp_state_t  r_state, w_state_n;
    logic [CW-1:0] r_col;
    logic [LW-1:0] r_line;
    logic [YW-1:0] r_y;
    pattern_t    r_pattern;
    logic [15:0] r_solid;
    logic        w_latch;
    logic        w_frame_end;
    logic        w_line_end;
    logic        w_href_s0;
    logic        w_y_bit3;
    logic [15:0] w_pix;

    assign w_line_end = (r_col == CW'(LP - 1));
    assign w_href_s0  = (r_state == ST_ACTIVE) && (r_col < CW'(2 * FRAME_WIDTH));

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_latch     = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_n = ST_VSYNC;
                    w_latch   = 1'b1;
                end
            end
            ST_VSYNC: begin
                if (w_line_end && (r_line == LW'(VSYNC_LINES - 1))) begin
                    w_state_n = ST_V_BACK;
                end
            end
            ST_V_BACK: begin
                if (w_line_end && (r_line == LW'(V_BACK_LINES - 1))) begin
                    w_state_n = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_line_end && (r_y == YW'(FRAME_HEIGHT - 1))) begin
                    w_state_n = ST_V_FRONT;
                end
            end
            ST_V_FRONT: begin
                if (w_line_end && (r_line == LW'(V_FRONT_LINES - 1))) begin
                    w_frame_end = 1'b1;
                    if (enable) begin
                        w_state_n = ST_VSYNC;
                        w_latch   = 1'b1;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // r_line counts blank-state lines, r_y counts active lines; both restart per state.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_col  <= '0;
            r_line <= '0;
            r_y    <= '0;
        end else if (r_state == ST_IDLE) begin
            r_col  <= '0;
            r_line <= '0;
            r_y    <= '0;
        end else begin
            r_col <= w_line_end ? '0 : r_col + CW'(1);
            if (w_line_end) begin
                if (w_state_n != r_state) begin
                    r_line <= '0;
                    r_y    <= '0;
                end else if (r_state == ST_ACTIVE) begin
                    r_y <= r_y + YW'(1);
                end else begin
                    r_line <= r_line + LW'(1);
                end
            end
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_pattern <= PAT_BARS;
            r_solid   <= 16'd0;
        end else if (w_latch) begin
            r_pattern <= pattern_t'(pattern_sel);
            r_solid   <= solid_rgb;
        end
    end

    // Checkerboard row phase for the line about to start.
    generate
        if (YW >= 4) begin : g_y_bit3
            logic [YW-1:0] w_y_next;
            assign w_y_next = (r_state == ST_ACTIVE) ? r_y + YW'(1) : '0;
            assign w_y_bit3 = w_y_next[3];
        end else begin : g_y_bit3_zero
            assign w_y_bit3 = 1'b0;
        end
    endgenerate

    ov7670_pattern_pixel #(
        .FRAME_WIDTH (FRAME_WIDTH)
    ) u_pattern_pixel (
        .PixelClk    (PixelClk),
        .nRST        (nRST),
        .pattern     (r_pattern),
        .frame_start ((r_state == ST_IDLE) || (r_state == ST_VSYNC)),
        .line_start  (w_line_end),
        .x_step      (w_href_s0 && r_col[0]),
        .y_bit3      (w_y_bit3),
        .solid       (r_solid),
        .pix         (w_pix)
    );

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            cam_vsync  <= 1'b0;
            href       <= 1'b0;
            p_data     <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            cam_vsync  <= (r_state == ST_VSYNC);
            href       <= w_href_s0;
            p_data     <= w_href_s0 ? (r_col[0] ? w_pix[7:0] : w_pix[15:8]) : 8'd0;
            frame_done <= w_frame_end;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ov7670_dvp_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_ov7670_dvp_source
// Description : Self-checking bench: frame-time model compared every cycle,
//               plus directed timing and reset checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_dvp_source;

    localparam int W     = 16;
    localparam int H     = 4;
    localparam int HB    = 8;
    localparam int VS    = 1;
    localparam int VB    = 2;
    localparam int VF    = 1;
    localparam int LP    = 2 * W + HB;
    localparam int FRAME = (VS + VB + H + VF) * LP;

    localparam logic [15:0] BAR_TAB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        PixelClk = 1'b0;
    logic        nRST = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd1;
    logic [15:0] solid_rgb = 16'h0000;
    logic        cam_vsync, href, frame_done;
    logic [7:0]  p_data;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    ov7670_dvp_source #(
        .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK_LINES(VB), .V_FRONT_LINES(VF)
    ) dut (
        .PixelClk(PixelClk), .nRST(nRST), .enable(enable),
        .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .cam_vsync(cam_vsync), .href(href), .p_data(p_data), .frame_done(frame_done)
    );

    always #5 PixelClk = ~PixelClk;
    always @(posedge PixelClk) edge_cnt++;

    function automatic logic [15:0] exp_pix(input logic [1:0] pat, input logic [15:0] sol,
                                            input int x, input int y);
        case (pat)
            2'd0:    return BAR_TAB[x / (W / 8)];
            2'd1:    return 16'((y * W + x) % 65536);
            2'd2:    return sol;
            default: return (((x / 8) + (y / 8)) % 2 == 1) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // {vsync, href, data[7:0], done} at frame-time s
    function automatic logic [10:0] exp_out(input int s, input logic [1:0] pat,
                                            input logic [15:0] sol);
        int ln, c, a;
        logic v, h;
        logic [15:0] px;
        logic [7:0] d;
        ln = s / LP;
        c  = s % LP;
        v  = (ln < VS);
        a  = ln - (VS + VB);
        h  = (a >= 0) && (a < H) && (c < 2 * W);
        d  = 8'h00;
        if (h) begin
            px = exp_pix(pat, sol, c / 2, a);
            d  = (c % 2 == 0) ? px[15:8] : px[7:0];
        end
        return {v, h, d, (s == FRAME - 1)};
    endfunction

    // Frame-time model: m_s is the frame cycle whose outputs appear after the next edge.
    logic        m_run = 1'b0;
    int          m_s = 0;
    logic [1:0]  m_pat = 2'd0;
    logic [15:0] m_sol = 16'd0;
    logic [10:0] exp_v = '0;

    always @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            m_run = 1'b0;
            m_s   = 0;
            exp_v = '0;
        end else begin
            exp_v = m_run ? exp_out(m_s, m_pat, m_sol) : 11'd0;
            if (!m_run) begin
                if (enable) begin
                    m_run = 1'b1; m_s = 0; m_pat = pattern_sel; m_sol = solid_rgb;
                end
            end else if (m_s == FRAME - 1) begin
                if (enable) begin
                    m_s = 0; m_pat = pattern_sel; m_sol = solid_rgb;
                end else begin
                    m_run = 1'b0;
                end
            end else begin
                m_s++;
            end
        end
    end

    always @(negedge PixelClk) begin
        n_checks++;
        if ({cam_vsync, href, p_data, frame_done} !== exp_v) begin
            n_errors++;
            $display("FAIL cycle edge %0d: vsync/href/data/done got %b/%b/%h/%b want %b/%b/%h/%b",
                     edge_cnt, cam_vsync, href, p_data, frame_done,
                     exp_v[10], exp_v[9], exp_v[8:1], exp_v[0]);
        end
    end

    // Frame statistics measured from each cam_vsync rise.
    int   fr_cyc = 0, vs_len = 0, first_href = 0, href_cnt = 0, href_rises = 0;
    int   run = 0, run_min = 999, run_max = 0, rise_cnt = 0;
    int   last_vs_len = 0, last_first_href = 0, last_done = 0, last_href_cnt = 0;
    int   last_rises = 0, last_run_min = 0, last_run_max = 0;
    logic prev_vs = 1'b0, prev_href = 1'b0;

    always @(negedge PixelClk) begin
        fr_cyc++;
        if (cam_vsync && !prev_vs) begin
            fr_cyc = 1; vs_len = 0; first_href = 0; href_cnt = 0; href_rises = 0;
            run_min = 999; run_max = 0; run = 0; rise_cnt++;
        end
        if (cam_vsync) vs_len++;
        if (href) begin
            href_cnt++;
            run++;
            if (!prev_href) href_rises++;
            if (first_href == 0) first_href = fr_cyc;
        end else if (prev_href) begin
            if (run < run_min) run_min = run;
            if (run > run_max) run_max = run;
            run = 0;
        end
        if (frame_done) begin
            last_done = fr_cyc; last_vs_len = vs_len; last_first_href = first_href;
            last_href_cnt = href_cnt; last_rises = href_rises;
            last_run_min = run_min; last_run_max = run_max;
        end
        prev_vs   = cam_vsync;
        prev_href = href;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic goto_edge(input int n);
        wait (edge_cnt >= n);
        #2;
    endtask

    task automatic check_frame_stats(input string tag);
        check({tag, " vsync_len"},  last_vs_len, 40);
        check({tag, " first_href"}, last_first_href, 121);
        check({tag, " done_cycle"}, last_done, 320);
        check({tag, " href_bytes"}, last_href_cnt, 128);
        check({tag, " href_lines"}, last_rises, 4);
        check({tag, " href_min"},   last_run_min, 32);
        check({tag, " href_max"},   last_run_max, 32);
    endtask

    int rises_before;

    initial begin
        check("model ramp y2x0",  exp_pix(2'd1, 16'h0, 0, 2),  16'h0020);
        check("model ramp y2x15", exp_pix(2'd1, 16'h0, 15, 2), 16'h002F);
        check("model bar x2",     exp_pix(2'd0, 16'h0, 2, 0),  16'hFFE0);
        check("model bar x15",    exp_pix(2'd0, 16'h0, 15, 1), 16'h0000);
        check("model chk x7",     exp_pix(2'd3, 16'h0, 7, 0),  16'h0000);
        check("model chk x8",     exp_pix(2'd3, 16'h0, 8, 0),  16'hFFFF);
        check("model solid",      exp_pix(2'd2, 16'hA55A, 3, 3), 16'hA55A);

        #1 nRST = 1'b0;
        #2;
        check("reset outputs", {cam_vsync, href, p_data, frame_done}, 11'd0);
        goto_edge(2);
        nRST = 1'b1;

        goto_edge(9);
        enable = 1'b1;
        pattern_sel = 2'd1;
        goto_edge(10);
        check("vsync low at edge 10", cam_vsync, 1'b0);
        goto_edge(11);
        check("vsync high at edge 11", cam_vsync, 1'b1);

        goto_edge(200);
        pattern_sel = 2'd0;
        goto_edge(340);
        check_frame_stats("frame1");
        goto_edge(500);
        pattern_sel = 2'd3;
        goto_edge(800);
        pattern_sel = 2'd2;
        solid_rgb   = 16'hA55A;
        goto_edge(1450);
        enable = 1'b0;
        goto_edge(1620);
        check_frame_stats("frame5");
        rises_before = rise_cnt;
        goto_edge(1700);
        pattern_sel = 2'd1;
        goto_edge(1790);
        check("no vsync while idle", rise_cnt - rises_before, 0);

        goto_edge(1799);
        enable = 1'b1;
        goto_edge(1935);
        check("href high before reset", href, 1'b1);
        nRST = 1'b0;
        #1;
        check("async reset outputs", {cam_vsync, href, p_data, frame_done}, 11'd0);
        goto_edge(1938);
        nRST = 1'b1;
        goto_edge(2270);
        check_frame_stats("restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
